// File: rtl/btn_gesture_ctrl_pkg.sv
// Shared definitions for the button gesture sequencer: event codes,
// FSM state encoding and the parameter legality check.
package btn_gesture_ctrl_pkg;

  localparam logic [2:0] EVT_NONE   = 3'd0;
  localparam logic [2:0] EVT_SHORT  = 3'd1;
  localparam logic [2:0] EVT_DOUBLE = 3'd2;
  localparam logic [2:0] EVT_LONG   = 3'd3;
  localparam logic [2:0] EVT_REPEAT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN1 = 3'd1,
    ST_HELD  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_DOWN2 = 3'd4
  } state_t;

  // True when the prescaler limit and all millisecond thresholds are usable
  // with a 16-bit saturating millisecond counter.
  function automatic bit params_ok(input int p, input int long_ms,
                                   input int double_ms, input int repeat_ms);
    return (p >= 2) &&
           (long_ms   >= 1) && (long_ms   <= 65535) &&
           (double_ms >= 1) && (double_ms <= 65535) &&
           (repeat_ms >= 1) && (repeat_ms <= 65535);
  endfunction

endpackage

// File: rtl/btn_gesture_ctrl_ms_timer.sv
// Millisecond timebase: a prescaler dividing clk by P and a 16-bit
// saturating millisecond counter. restart clears both on the next edge.
module ms_timer #(
  parameter int P = 27_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  output logic        tick,
  output logic [15:0] ms_cnt
);

  // Guard keeps the width legal even when P is rejected by the parent.
  localparam int PW = (P > 2) ? $clog2(P) : 1;

  logic [PW-1:0] presc_reg;
  logic [15:0]   ms_reg;

  assign tick   = (presc_reg == PW'(P - 1));
  assign ms_cnt = ms_reg;

  // Prescaler wraps at P-1; ms counter advances on tick and sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      ms_reg    <= '0;
    end else if (restart) begin
      presc_reg <= '0;
      ms_reg    <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick && (ms_reg != 16'hFFFF)) begin
        ms_reg <= ms_reg + 16'd1;
      end
    end
  end

endmodule

// File: rtl/btn_gesture_ctrl.sv
// Gesture sequencer: turns press/rel pulses from the edge detector into
// SHORT / DOUBLE / LONG / REPEAT events, one registered strobe per event.
module btn_gesture_ctrl
  import btn_gesture_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 27_000_000,
  parameter int LONG_MS   = 600,
  parameter int DOUBLE_MS = 250,
  parameter int REPEAT_MS = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press,
  input  logic       rel,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       busy
);

  localparam int P = CLK_HZ / 1000;

  generate
    if (!params_ok(P, LONG_MS, DOUBLE_MS, REPEAT_MS)) begin : g_bad_params
      $error("btn_gesture_ctrl: need CLK_HZ/1000 >= 2 and *_MS in 1..65535");
    end
  endgenerate

  state_t      state_reg, state_next;
  logic        evt_valid_reg, evt_valid_next;
  logic [2:0]  evt_code_reg, evt_code_next;
  logic        busy_reg;
  logic        rep_restart;
  logic        timer_restart;
  logic        tick;
  logic [15:0] ms_cnt;
  logic        press_eff;
  logic        long_hit, double_hit, repeat_hit;

  // A press coinciding with a release is dropped; the release is handled.
  assign press_eff = press && !rel;

  // A threshold of N ms is reached on the tick that ends millisecond N-1.
  assign long_hit   = tick && (ms_cnt == 16'(LONG_MS - 1));
  assign double_hit = tick && (ms_cnt == 16'(DOUBLE_MS - 1));
  assign repeat_hit = tick && (ms_cnt == 16'(REPEAT_MS - 1));

  // Every state change, and every REPEAT, starts timing afresh.
  assign timer_restart = (state_next != state_reg) || rep_restart;

  ms_timer #(.P(P)) u_ms_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (timer_restart),
    .tick    (tick),
    .ms_cnt  (ms_cnt)
  );

  // State, event and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      evt_valid_reg <= 1'b0;
      evt_code_reg  <= EVT_NONE;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      evt_valid_reg <= evt_valid_next;
      evt_code_reg  <= evt_code_next;
      busy_reg      <= (state_reg != ST_IDLE);
    end
  end

  // Next-state and event decode; release always beats a timer threshold.
  always_comb begin
    state_next     = state_reg;
    evt_valid_next = 1'b0;
    evt_code_next  = EVT_NONE;
    rep_restart    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (press_eff) state_next = ST_DOWN1;
      end
      ST_DOWN1: begin
        if (rel) begin
          state_next = ST_WAIT2;
        end else if (long_hit) begin
          state_next     = ST_HELD;
          evt_valid_next = 1'b1;
          evt_code_next  = EVT_LONG;
        end
      end
      ST_HELD: begin
        if (rel) begin
          state_next = ST_IDLE;
        end else if (repeat_hit) begin
          evt_valid_next = 1'b1;
          evt_code_next  = EVT_REPEAT;
          rep_restart    = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (press_eff) begin
          state_next = ST_DOWN2;
        end else if (double_hit) begin
          state_next     = ST_IDLE;
          evt_valid_next = 1'b1;
          evt_code_next  = EVT_SHORT;
        end
      end
      ST_DOWN2: begin
        if (rel) begin
          state_next     = ST_IDLE;
          evt_valid_next = 1'b1;
          evt_code_next  = EVT_DOUBLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign evt_valid = evt_valid_reg;
  assign evt_code  = evt_code_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_btn_gesture_ctrl.sv
// Self-checking bench for btn_gesture_ctrl: directed gesture scenarios plus
// random press/rel traffic, all compared against an elapsed-cycle model.
module tb_btn_gesture_ctrl;

  localparam int CLK_HZ    = 10_000;
  localparam int LONG_MS   = 5;
  localparam int DOUBLE_MS = 3;
  localparam int REPEAT_MS = 2;
  localparam int CPM       = CLK_HZ / 1000;
  localparam int LONG_CYC  = LONG_MS * CPM;
  localparam int DBL_CYC   = DOUBLE_MS * CPM;
  localparam int REP_CYC   = REPEAT_MS * CPM;

  localparam logic [2:0] C_SHORT  = 3'd1;
  localparam logic [2:0] C_DOUBLE = 3'd2;
  localparam logic [2:0] C_LONG   = 3'd3;
  localparam logic [2:0] C_REPEAT = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       press = 1'b0;
  logic       rel = 1'b0;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  btn_gesture_ctrl #(
    .CLK_HZ(CLK_HZ), .LONG_MS(LONG_MS), .DOUBLE_MS(DOUBLE_MS), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .press(press), .rel(rel),
    .evt_valid(evt_valid), .evt_code(evt_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: gesture phase plus cycles elapsed since the phase began.
  typedef enum {M_IDLE, M_DOWN1, M_HELD, M_WAIT2, M_DOWN2} mphase_t;
  mphase_t    m_phase;
  int         m_age;
  logic       m_valid;
  logic [2:0] m_code;
  logic       m_busy;

  function automatic void model_reset();
    m_phase = M_IDLE;
    m_age   = 0;
    m_valid = 1'b0;
    m_code  = 3'd0;
    m_busy  = 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample at +1.
  task automatic step(input logic p, input logic r);
    int age_now;
    bit fresh;
    press = p;
    rel   = r;
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_busy  = (m_phase != M_IDLE);
      m_valid = 1'b0;
      m_code  = 3'd0;
      age_now = m_age + 1;
      fresh   = 1'b0;
      case (m_phase)
        M_IDLE:  if (p && !r) begin m_phase = M_DOWN1; fresh = 1; end
        M_DOWN1: if (r) begin m_phase = M_WAIT2; fresh = 1; end
                 else if (age_now == LONG_CYC) begin
                   m_phase = M_HELD; m_valid = 1; m_code = C_LONG; fresh = 1;
                 end
        M_HELD:  if (r) begin m_phase = M_IDLE; fresh = 1; end
                 else if (age_now == REP_CYC) begin
                   m_valid = 1; m_code = C_REPEAT; fresh = 1;
                 end
        M_WAIT2: if (p && !r) begin m_phase = M_DOWN2; fresh = 1; end
                 else if (age_now == DBL_CYC) begin
                   m_phase = M_IDLE; m_valid = 1; m_code = C_SHORT; fresh = 1;
                 end
        M_DOWN2: if (r) begin
                   m_phase = M_IDLE; m_valid = 1; m_code = C_DOUBLE; fresh = 1;
                 end
        default: m_phase = M_IDLE;
      endcase
      m_age = fresh ? 0 : age_now;
    end
    #1;
    if (evt_valid) $display("cycle %0d: event code %0d", cyc, evt_code);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({evt_valid, evt_code, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state got v=%0b code=%0d busy=%0b want all 0", evt_valid, evt_code, busy);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
    end
  endtask

  task automatic test_short();
    int ev_c[$];
    logic [2:0] ev_k[$];
    for (int c = 0; c < 60; c++) begin
      step(c == 0, c == 20);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL short_model c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
      if (evt_valid) begin ev_c.push_back(c); ev_k.push_back(evt_code); end
      if (c == 50 || c == 51) begin
        n_checks++;
        if (busy !== (c == 50)) begin
          n_fail++;
          $display("FAIL short_busy c=%0d got %0b want %0b", c, busy, (c == 50));
        end
      end
    end
    n_checks++;
    if (ev_c.size() != 1 || ev_c[0] != 50 || ev_k[0] != C_SHORT) begin
      n_fail++;
      $display("FAIL short_event got n=%0d first_c=%0d code=%0d want n=1 c=50 code=1",
               ev_c.size(), ev_c.size() > 0 ? ev_c[0] : -1, ev_k.size() > 0 ? ev_k[0] : 3'd0);
    end
  endtask

  task automatic test_double();
    int ev_c[$];
    logic [2:0] ev_k[$];
    for (int c = 0; c < 80; c++) begin
      step(c == 0 || c == 25, c == 10 || c == 35);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL double_model c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
      if (evt_valid) begin ev_c.push_back(c); ev_k.push_back(evt_code); end
    end
    n_checks++;
    if (ev_c.size() != 1 || ev_c[0] != 35 || ev_k[0] != C_DOUBLE) begin
      n_fail++;
      $display("FAIL double_event got n=%0d first_c=%0d code=%0d want n=1 c=35 code=2",
               ev_c.size(), ev_c.size() > 0 ? ev_c[0] : -1, ev_k.size() > 0 ? ev_k[0] : 3'd0);
    end
  endtask

  task automatic test_long_repeat();
    int ev_c[$];
    logic [2:0] ev_k[$];
    int exp_c[3] = '{50, 70, 90};
    logic [2:0] exp_k[3] = '{C_LONG, C_REPEAT, C_REPEAT};
    for (int c = 0; c < 140; c++) begin
      step(c == 0, c == 100);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL long_model c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
      if (evt_valid) begin ev_c.push_back(c); ev_k.push_back(evt_code); end
    end
    n_checks++;
    if (ev_c.size() != 3) begin
      n_fail++;
      $display("FAIL long_count got %0d events want 3", ev_c.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (ev_c[i] != exp_c[i] || ev_k[i] != exp_k[i]) begin
          n_fail++;
          $display("FAIL long_event%0d got c=%0d code=%0d want c=%0d code=%0d", i, ev_c[i], ev_k[i], exp_c[i], exp_k[i]);
        end
      end
    end
  endtask

  // Release just before and exactly on the LONG threshold: never LONG.
  task automatic test_long_boundary();
    for (int k = 49; k <= 50; k++) begin
      int ev_c[$];
      logic [2:0] ev_k[$];
      for (int c = 0; c < 95; c++) begin
        step(c == 0, c == k);
        n_checks++;
        if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
          n_fail++;
          $display("FAIL lbound_model k=%0d c=%0d got %b want %b", k, c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
        end
        if (evt_valid) begin ev_c.push_back(c); ev_k.push_back(evt_code); end
      end
      n_checks++;
      if (ev_c.size() != 1 || ev_c[0] != k + 30 || ev_k[0] != C_SHORT) begin
        n_fail++;
        $display("FAIL lbound_event k=%0d got n=%0d first_c=%0d code=%0d want n=1 c=%0d code=1", k,
                 ev_c.size(), ev_c.size() > 0 ? ev_c[0] : -1, ev_k.size() > 0 ? ev_k[0] : 3'd0, k + 30);
      end
    end
  endtask

  // Second press lands on the same edge the SHORT timeout would fire.
  task automatic test_double_boundary();
    int ev_c[$];
    logic [2:0] ev_k[$];
    for (int c = 0; c < 80; c++) begin
      step(c == 0 || c == 40, c == 10 || c == 50);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL dbound_model c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
      if (evt_valid) begin ev_c.push_back(c); ev_k.push_back(evt_code); end
    end
    n_checks++;
    if (ev_c.size() != 1 || ev_c[0] != 50 || ev_k[0] != C_DOUBLE) begin
      n_fail++;
      $display("FAIL dbound_event got n=%0d first_c=%0d code=%0d want n=1 c=50 code=2",
               ev_c.size(), ev_c.size() > 0 ? ev_c[0] : -1, ev_k.size() > 0 ? ev_k[0] : 3'd0);
    end
  endtask

  // press+rel together in DOWN1 acts as a plain release.
  task automatic test_priority();
    int ev_c[$];
    logic [2:0] ev_k[$];
    for (int c = 0; c < 60; c++) begin
      step(c == 0 || c == 10, c == 10);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL prio_model c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
      if (evt_valid) begin ev_c.push_back(c); ev_k.push_back(evt_code); end
    end
    n_checks++;
    if (ev_c.size() != 1 || ev_c[0] != 40 || ev_k[0] != C_SHORT) begin
      n_fail++;
      $display("FAIL prio_event got n=%0d first_c=%0d code=%0d want n=1 c=40 code=1",
               ev_c.size(), ev_c.size() > 0 ? ev_c[0] : -1, ev_k.size() > 0 ? ev_k[0] : 3'd0);
    end
  endtask

  task automatic test_reset_mid();
    int n_ev = 0;
    for (int c = 0; c < 40; c++) step(c == 0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({evt_valid, evt_code, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async got v=%0b code=%0d busy=%0b want all 0", evt_valid, evt_code, busy);
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_quiet c=%0d got %b want 00000", c, {evt_valid, evt_code, busy});
      end
      if (evt_valid) n_ev++;
    end
    for (int c = 0; c < 60; c++) begin
      step(c == 0, c == 20);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL reset_after c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
      if (evt_valid) n_ev++;
    end
    n_checks++;
    if (n_ev != 1) begin
      n_fail++;
      $display("FAIL reset_events got %0d events want 1", n_ev);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);
      n_checks++;
      if ({evt_valid, evt_code, busy} !== {m_valid, m_code, m_busy}) begin
        n_fail++;
        $display("FAIL random_model c=%0d got %b want %b", c, {evt_valid, evt_code, busy}, {m_valid, m_code, m_busy});
      end
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_long_boundary();
    test_double_boundary();
    test_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
